// File: rtl/prog_mem_stream_loader_pkg.sv
// prog_mem_loader_pkg: shared types and helpers for the program-memory stream loader.
//   state_e    : loader FSM states
//   ERR_*      : err_code encodings
//   BC_W/NW_W  : byte-count and word-count widths
//   lane_mask  : byteenable for a word given the image tail length
//   byte_sum   : sum of the enabled byte lanes of a word
package prog_mem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_VADDR,
    S_VDATA,
    S_DONE,
    S_ERROR
  } state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_RANGE    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_MISMATCH = 2'd3;

  localparam int BC_W = 17;
  // ceil(byte_count/4) of a 17-bit count always fits in 16 bits
  localparam int NW_W = BC_W - 1;

  // Only the final word of an image with a ragged tail is partially enabled.
  function automatic logic [3:0] lane_mask(input logic [1:0] tail, input logic is_last);
    logic [3:0] m;
    m = 4'b1111;
    if (is_last) begin
      case (tail)
        2'd1:    m = 4'b0001;
        2'd2:    m = 4'b0011;
        2'd3:    m = 4'b0111;
        default: m = 4'b1111;
      endcase
    end
    return m;
  endfunction

  function automatic logic [31:0] byte_sum(input logic [31:0] word, input logic [3:0] mask);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) s = s + {24'd0, word[8*i +: 8]};
    end
    return s;
  endfunction

endpackage

// File: rtl/prog_mem_stream_loader_if.sv
// prog_mem_stream_loader_if: single-port program memory bus.
//   master : loader side (drives address/byteenable/chipselect/write/writedata/clken)
//   slave  : memory side (returns readdata one cycle after a read address)
interface prog_mem_stream_loader_if #(
  parameter int ADDR_W = 15
);
  logic [ADDR_W-1:0] address;
  logic [3:0]        byteenable;
  logic              chipselect;
  logic              write;
  logic [31:0]       writedata;
  logic              clken;
  logic [31:0]       readdata;

  modport master (
    output address, byteenable, chipselect, write, writedata, clken,
    input  readdata
  );

  modport slave (
    input  address, byteenable, chipselect, write, writedata, clken,
    output readdata
  );
endinterface

// File: rtl/prog_mem_stream_loader_packer.sv
// prog_mem_word_packer: packs stream bytes little-endian into a 32-bit word.
//   i_clear       : restart assembly (new image or word just written)
//   i_push        : byte accepted this cycle; i_byte goes to the current lane
//   i_last_byte   : the pushed byte is the final byte of the image
//   i_tail        : image byte count mod 4, for the final word's lane mask
//   o_word        : assembled word, unfilled lanes are zero
//   o_word_ready  : this push completes a word (lane 3 or last byte)
//   o_byteenable  : lane mask for the assembled word
module prog_mem_word_packer
  import prog_mem_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clear,
  input  logic        i_push,
  input  logic [7:0]  i_byte,
  input  logic        i_last_byte,
  input  logic [1:0]  i_tail,
  output logic [31:0] o_word,
  output logic        o_word_ready,
  output logic [3:0]  o_byteenable
);

  logic [1:0]  r_lane;
  logic [31:0] r_word;
  logic        r_last;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_lane <= '0;
      r_word <= '0;
      r_last <= 1'b0;
    end else if (i_push) begin
      r_word[{r_lane, 3'b000} +: 8] <= i_byte;
      r_lane                        <= r_lane + 2'd1;
      if (i_last_byte) r_last <= 1'b1;
    end
  end

  assign o_word       = r_word;
  assign o_word_ready = i_push && ((r_lane == 2'd3) || i_last_byte);
  assign o_byteenable = lane_mask(i_tail, r_last);

endmodule

// File: rtl/prog_mem_stream_loader.sv
// prog_mem_stream_loader: loads a byte-stream program image into program memory,
// reads it back to verify a byte checksum, and holds the CPU in reset meanwhile.
//   i_clk, i_reset          : clock, synchronous active-high reset
//   i_start, i_base_addr,
//   i_byte_count            : load request (sampled when start is accepted)
//   i_in_data/i_in_valid,
//   o_in_ready              : byte stream handshake
//   mem_if                  : program memory bus (master)
//   o_busy, o_done, o_error,
//   o_err_code, o_checksum  : status
//   o_cpu_hold              : processor reset request
//
// state   | meaning
// IDLE    | waiting for start
// LOAD    | accepting stream bytes into the packer
// WRITE   | writing the packed word
// VADDR   | issuing a readback address
// VDATA   | accumulating readback bytes, comparing on the last word
// DONE    | image verified, CPU released
// ERROR   | range / timeout / mismatch, CPU still held
module prog_mem_stream_loader
  import prog_mem_loader_pkg::*;
#(
  parameter int ADDR_W      = 15,
  parameter int DEPTH       = 28912,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [BC_W-1:0]   i_byte_count,
  input  logic [7:0]        i_in_data,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  prog_mem_stream_loader_if.master mem_if,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [1:0]        o_err_code,
  output logic [31:0]       o_checksum,
  output logic              o_cpu_hold
);

  // end-address arithmetic is wide enough that base+nwords never wraps
  localparam int END_W = 18;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);

  state_e            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_base;
  logic [BC_W-1:0]   r_byte_count, r_byte_idx;
  logic [NW_W-1:0]   r_nwords, r_word_idx;
  logic [31:0]       r_load_sum, r_ver_sum, r_checksum;
  logic [TMO_W-1:0]  r_idle_cnt;
  logic              r_done, r_error, r_cpu_hold;
  logic [1:0]        r_err_code;

  logic              w_accept, w_push, w_last_byte, w_more_bytes, w_tmo;
  logic              w_ver_last, w_match, w_to_done, w_to_range, w_to_mismatch;
  logic [NW_W-1:0]   w_nwords;
  logic [END_W-1:0]  w_end;
  logic [31:0]       w_ver_sum_nxt, w_pack_word;
  logic [3:0]        w_pack_be, w_ver_be;
  logic              w_word_ready, w_pack_clear;
  logic [ADDR_W-1:0] w_addr;

  assign w_accept      = i_start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERROR);
  assign w_nwords      = NW_W'((END_W'(i_byte_count) + END_W'(3)) >> 2);
  assign w_end         = END_W'(i_base_addr) + END_W'(w_nwords);
  assign w_push        = (r_state == S_LOAD) && i_in_valid;
  assign w_last_byte   = (r_byte_idx + BC_W'(1)) == r_byte_count;
  assign w_more_bytes  = r_byte_idx != r_byte_count;
  assign w_tmo         = (r_state == S_LOAD) && !i_in_valid && (r_idle_cnt == '0);
  assign w_ver_last    = (r_word_idx + NW_W'(1)) == r_nwords;
  assign w_ver_be      = lane_mask(r_byte_count[1:0], w_ver_last);
  assign w_ver_sum_nxt = r_ver_sum + byte_sum(mem_if.readdata, w_ver_be);
  assign w_match       = w_ver_sum_nxt == r_load_sum;
  assign w_to_done     = (w_accept && i_byte_count == '0) ||
                         (r_state == S_VDATA && w_ver_last && w_match);
  assign w_to_range    = w_accept && i_byte_count != '0 && w_end > END_W'(DEPTH);
  assign w_to_mismatch = (r_state == S_VDATA) && w_ver_last && !w_match;
  assign w_addr        = r_base + r_word_idx[ADDR_W-1:0];
  // clearing after each write keeps the unfilled lanes of a tail word at zero
  assign w_pack_clear  = w_accept || (r_state == S_WRITE);

  prog_mem_word_packer u_packer (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clear      (w_pack_clear),
    .i_push       (w_push),
    .i_byte       (i_in_data),
    .i_last_byte  (w_last_byte),
    .i_tail       (r_byte_count[1:0]),
    .o_word       (w_pack_word),
    .o_word_ready (w_word_ready),
    .o_byteenable (w_pack_be)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (w_accept) begin
          if (i_byte_count == '0) w_state_nxt = S_DONE;
          else if (w_to_range)    w_state_nxt = S_ERROR;
          else                    w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_word_ready) w_state_nxt = S_WRITE;
        else if (w_tmo)   w_state_nxt = S_ERROR;
      end
      S_WRITE: w_state_nxt = w_more_bytes ? S_LOAD : S_VADDR;
      S_VADDR: w_state_nxt = S_VDATA;
      S_VDATA: begin
        if (!w_ver_last) w_state_nxt = S_VADDR;
        else if (w_match) w_state_nxt = S_DONE;
        else             w_state_nxt = S_ERROR;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_in_ready           = 1'b0;
    o_busy               = 1'b0;
    mem_if.chipselect    = 1'b0;
    mem_if.write         = 1'b0;
    mem_if.address       = '0;
    mem_if.byteenable    = '0;
    mem_if.writedata     = '0;
    case (r_state)
      S_LOAD: begin
        o_in_ready = 1'b1;
        o_busy     = 1'b1;
      end
      S_WRITE: begin
        o_busy            = 1'b1;
        mem_if.chipselect = 1'b1;
        mem_if.write      = 1'b1;
        mem_if.address    = w_addr;
        mem_if.byteenable = w_pack_be;
        mem_if.writedata  = w_pack_word;
      end
      S_VADDR: begin
        o_busy            = 1'b1;
        mem_if.chipselect = 1'b1;
        mem_if.address    = w_addr;
        mem_if.byteenable = w_ver_be;
      end
      S_VDATA: o_busy = 1'b1;
      default: ;
    endcase
  end

  assign mem_if.clken = 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_base       <= '0;
      r_byte_count <= '0;
      r_nwords     <= '0;
      r_byte_idx   <= '0;
      r_word_idx   <= '0;
      r_load_sum   <= '0;
      r_ver_sum    <= '0;
      r_checksum   <= '0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_err_code   <= ERR_NONE;
      r_cpu_hold   <= 1'b0;
    end else begin
      r_done <= w_to_done;
      if (w_accept) begin
        r_base       <= i_base_addr;
        r_byte_count <= i_byte_count;
        r_nwords     <= w_nwords;
        r_byte_idx   <= '0;
        r_word_idx   <= '0;
        r_load_sum   <= '0;
        r_ver_sum    <= '0;
        r_error      <= 1'b0;
        r_err_code   <= ERR_NONE;
        r_cpu_hold   <= 1'b1;
      end
      if (w_push) begin
        r_byte_idx <= r_byte_idx + BC_W'(1);
        r_load_sum <= r_load_sum + {24'd0, i_in_data};
      end
      if (r_state == S_WRITE) r_word_idx <= w_more_bytes ? r_word_idx + NW_W'(1) : '0;
      if (r_state == S_VDATA) begin
        r_ver_sum <= w_ver_sum_nxt;
        if (!w_ver_last) r_word_idx <= r_word_idx + NW_W'(1);
      end
      // an empty image completes straight from an idle state with a zero checksum
      if (w_to_done) begin
        r_cpu_hold <= 1'b0;
        r_checksum <= (r_state == S_VDATA) ? r_load_sum : '0;
      end
      if (w_to_range || w_tmo || w_to_mismatch) begin
        r_error    <= 1'b1;
        r_err_code <= w_to_range ? ERR_RANGE : (w_tmo ? ERR_TIMEOUT : ERR_MISMATCH);
      end
    end
  end

  // idle-cycle down-counter; reloads on every accepted byte and outside LOAD
  always_ff @(posedge i_clk) begin
    if (i_reset || w_push || r_state != S_LOAD) r_idle_cnt <= TMO_LOAD;
    else if (r_idle_cnt != '0)                  r_idle_cnt <= r_idle_cnt - TMO_W'(1);
  end

  assign o_done     = r_done;
  assign o_error    = r_error;
  assign o_err_code = r_err_code;
  assign o_checksum = r_checksum;
  assign o_cpu_hold = r_cpu_hold;

endmodule
